// File: rtl/lifo_stack_if.sv
// lifo_stack_if: request/data/status bundle for lifo_stack.
// The master side issues push/pop requests and observes the stack status;
// the slave side is the stack itself. Clock and reset travel outside the
// interface as plain ports.
interface lifo_stack_if #(
    parameter int p_STACK_DEPTH = 8,
    parameter int p_DATA_WIDTH  = 8
);
    localparam int lp_COUNT_WIDTH = $clog2(p_STACK_DEPTH + 1);

    logic                      i_WRITE_REQUEST;
    logic                      i_READ_REQUEST;
    logic [p_DATA_WIDTH-1:0]   i_INPUT;
    logic [p_DATA_WIDTH-1:0]   o_OUTPUT;
    logic                      o_VALID;
    logic [p_DATA_WIDTH-1:0]   o_TOP;
    logic [lp_COUNT_WIDTH-1:0] o_COUNT;
    logic                      o_STACK_FULL;
    logic                      o_STACK_EMPTY;
    logic                      o_ALMOST_FULL;
    logic                      o_OVERFLOW;
    logic                      o_UNDERFLOW;

    modport master (
        output i_WRITE_REQUEST, i_READ_REQUEST, i_INPUT,
        input  o_OUTPUT, o_VALID, o_TOP, o_COUNT, o_STACK_FULL,
               o_STACK_EMPTY, o_ALMOST_FULL, o_OVERFLOW, o_UNDERFLOW
    );

    modport slave (
        input  i_WRITE_REQUEST, i_READ_REQUEST, i_INPUT,
        output o_OUTPUT, o_VALID, o_TOP, o_COUNT, o_STACK_FULL,
               o_STACK_EMPTY, o_ALMOST_FULL, o_OVERFLOW, o_UNDERFLOW
    );
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with registered pop data, a combinational
// top-of-stack peek, occupancy count and overflow/underflow pulses.
// The occupancy count doubles as the stack pointer: the next free slot is
// mem[count] and the top is mem[count-1]; its width covers 0..depth so it
// never wraps.
// Optional feature macro: LIFO_STACK_ALMOST_FULL_EN (enables o_ALMOST_FULL
// as count >= p_AF_THRESHOLD; otherwise the output is tied low).
module lifo_stack #(
    parameter int p_STACK_DEPTH  = 8,
    parameter int p_DATA_WIDTH   = 8,
    parameter int p_AF_THRESHOLD = 6
) (
    input  logic         i_CLK,
    input  logic         i_RESET,
    lifo_stack_if.slave  bus
);
    localparam int lp_CW = $clog2(p_STACK_DEPTH + 1);
    localparam logic [lp_CW-1:0] lp_DEPTH = lp_CW'(p_STACK_DEPTH);

    // Storage is never cleared; only the count decides what is live.
    logic [p_DATA_WIDTH-1:0] r_mem [p_STACK_DEPTH];

    logic [lp_CW-1:0]        r_count;
    logic [p_DATA_WIDTH-1:0] r_output;
    logic                    r_valid;
    logic                    r_overflow;
    logic                    r_underflow;

    logic [lp_CW-1:0]        w_count_next;
    logic [p_DATA_WIDTH-1:0] w_output_next;
    logic                    w_valid_next;
    logic                    w_overflow_next;
    logic                    w_underflow_next;
    logic                    w_do_push;
    logic                    w_do_replace;
    logic                    w_full;
    logic                    w_empty;
    logic [p_DATA_WIDTH-1:0] w_top;

    logic [p_STACK_DEPTH-1:0]                   w_wr_sel;
    logic [p_STACK_DEPTH-1:0][p_DATA_WIDTH-1:0] w_top_terms;

    assign w_full  = (r_count == lp_DEPTH);
    assign w_empty = (r_count == '0);

    // Per-entry decode: a plain push lands at mem[count], a replace-top
    // overwrites mem[count-1]. The peek term for an entry is live only when
    // that entry is the current top, so the OR of all terms is 0 when empty.
    generate
        for (genvar gi = 0; gi < p_STACK_DEPTH; gi++) begin : g_entry
            assign w_wr_sel[gi] = (w_do_push    && (r_count == lp_CW'(gi))) ||
                                  (w_do_replace && (r_count == lp_CW'(gi + 1)));
            assign w_top_terms[gi] = (r_count == lp_CW'(gi + 1)) ? r_mem[gi]
                                                                 : '0;
        end
    endgenerate

    // Collapse the one-hot top selection into the peek value.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < p_STACK_DEPTH; i++) begin
            w_top = w_top | w_top_terms[i];
        end
    end

    // Request resolution: every request is accepted or rejected this cycle.
    always_comb begin
        w_count_next     = r_count;
        w_output_next    = r_output;
        w_valid_next     = 1'b0;
        w_overflow_next  = 1'b0;
        w_underflow_next = 1'b0;
        w_do_push        = 1'b0;
        w_do_replace     = 1'b0;
        case ({bus.i_WRITE_REQUEST, bus.i_READ_REQUEST})
            2'b11: begin
                // Simultaneous push/pop never errors: pass-through when
                // empty, otherwise swap the top entry.
                w_valid_next = 1'b1;
                if (w_empty) begin
                    w_output_next = bus.i_INPUT;
                end else begin
                    w_output_next = w_top;
                    w_do_replace  = 1'b1;
                end
            end
            2'b10: begin
                if (w_full) begin
                    w_overflow_next = 1'b1;
                end else begin
                    w_do_push    = 1'b1;
                    w_count_next = r_count + lp_CW'(1);
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_underflow_next = 1'b1;
                end else begin
                    w_output_next = w_top;
                    w_valid_next  = 1'b1;
                    w_count_next  = r_count - lp_CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Entry writes; suppressed under reset so reset wins over a push.
    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            for (int i = 0; i < p_STACK_DEPTH; i++) begin
                if (w_wr_sel[i]) begin
                    r_mem[i] <= bus.i_INPUT;
                end
            end
        end
    end

    // Pointer, pop data and single-cycle strobes.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_count     <= '0;
            r_output    <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_output    <= w_output_next;
            r_valid     <= w_valid_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end
    end

    assign bus.o_OUTPUT      = r_output;
    assign bus.o_VALID       = r_valid;
    assign bus.o_TOP         = w_top;
    assign bus.o_COUNT       = r_count;
    assign bus.o_STACK_FULL  = w_full;
    assign bus.o_STACK_EMPTY = w_empty;
    assign bus.o_OVERFLOW    = r_overflow;
    assign bus.o_UNDERFLOW   = r_underflow;

`ifdef LIFO_STACK_ALMOST_FULL_EN
    assign bus.o_ALMOST_FULL = (r_count >= lp_CW'(p_AF_THRESHOLD));
`else
    assign bus.o_ALMOST_FULL = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed scenarios plus randomized traffic for lifo_stack,
// checked against a queue-based reference model.
module tb_lifo_stack;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int AFT   = 3;
`ifdef LIFO_STACK_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lifo_stack_if #(.p_STACK_DEPTH(DEPTH), .p_DATA_WIDTH(DW)) bus ();

    lifo_stack #(
        .p_STACK_DEPTH (DEPTH),
        .p_DATA_WIDTH  (DW),
        .p_AF_THRESHOLD(AFT)
    ) dut (
        .i_CLK  (clk),
        .i_RESET(rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stack is a queue whose back is the top.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_out = '0;
    logic          exp_valid = 1'b0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    function automatic logic [DW-1:0] exp_top();
        return (q.size() == 0) ? '0 : q[q.size()-1];
    endfunction

    function automatic logic exp_af();
        return AF_EN && (q.size() >= AFT);
    endfunction

    // Drive one cycle of requests, advance past the edge, update the model.
    task automatic do_cycle(input logic wr, input logic rd, input logic rs,
                            input logic [DW-1:0] din);
        bus.i_WRITE_REQUEST = wr;
        bus.i_READ_REQUEST  = rd;
        bus.i_INPUT         = din;
        rst                 = rs;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        if (rs) begin
            q.delete();
            exp_out = '0;
        end else if (wr && rd) begin
            exp_valid = 1'b1;
            if (q.size() == 0) begin
                exp_out = din;
            end else begin
                exp_out = q[q.size()-1];
                q[q.size()-1] = din;
            end
        end else if (wr) begin
            if (q.size() == DEPTH) exp_ovf = 1'b1;
            else q.push_back(din);
        end else if (rd) begin
            if (q.size() == 0) begin
                exp_unf = 1'b1;
            end else begin
                exp_out   = q.pop_back();
                exp_valid = 1'b1;
            end
        end
        bus.i_WRITE_REQUEST = 1'b0;
        bus.i_READ_REQUEST  = 1'b0;
        rst                 = 1'b0;
    endtask

    task automatic test_reset();
        do_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (bus.o_COUNT !== 3'd0 || bus.o_VALID !== 1'b0 || bus.o_OUTPUT !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d valid=%b out=%h required count=0 valid=0 out=00",
                     bus.o_COUNT, bus.o_VALID, bus.o_OUTPUT);
        end
        n_checks++;
        if ({bus.o_STACK_EMPTY, bus.o_STACK_FULL, bus.o_OVERFLOW, bus.o_UNDERFLOW, bus.o_ALMOST_FULL} !== 5'b10000
            || bus.o_TOP !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: e/f/ovf/unf/af=%b top=%h required 10000 top=00",
                     {bus.o_STACK_EMPTY, bus.o_STACK_FULL, bus.o_OVERFLOW, bus.o_UNDERFLOW, bus.o_ALMOST_FULL},
                     bus.o_TOP);
        end
        $display("test_reset: count=%0d empty=%b", bus.o_COUNT, bus.o_STACK_EMPTY);
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b0, 1'b0, vals[i]);
            n_checks++;
            if (bus.o_COUNT !== 3'(i + 1) || bus.o_TOP !== vals[i]) begin
                n_fail++;
                $display("FAIL fill_push%0d: count=%0d top=%h required count=%0d top=%h",
                         i, bus.o_COUNT, bus.o_TOP, i + 1, vals[i]);
            end
            n_checks++;
            if (bus.o_ALMOST_FULL !== (AF_EN && (i + 1 >= AFT))) begin
                n_fail++;
                $display("FAIL fill_af%0d: af=%b required %b", i, bus.o_ALMOST_FULL,
                         AF_EN && (i + 1 >= AFT));
            end
            $display("push %h: count=%0d top=%h af=%b", vals[i], bus.o_COUNT, bus.o_TOP, bus.o_ALMOST_FULL);
        end
        n_checks++;
        if (bus.o_STACK_FULL !== 1'b1 || bus.o_STACK_EMPTY !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: full=%b empty=%b required full=1 empty=0",
                     bus.o_STACK_FULL, bus.o_STACK_EMPTY);
        end
    endtask

    task automatic test_overflow();
        do_cycle(1'b1, 1'b0, 1'b0, 8'h55);
        n_checks++;
        if (bus.o_OVERFLOW !== 1'b1 || bus.o_COUNT !== 3'd4 || bus.o_TOP !== 8'h44) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b count=%0d top=%h required ovf=1 count=4 top=44",
                     bus.o_OVERFLOW, bus.o_COUNT, bus.o_TOP);
        end
        $display("push 55 on full: ovf=%b count=%0d top=%h", bus.o_OVERFLOW, bus.o_COUNT, bus.o_TOP);
        do_cycle(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (bus.o_OVERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_pulse: ovf=%b required 0", bus.o_OVERFLOW);
        end
    endtask

    task automatic test_pop_all();
        logic [DW-1:0] vals [4];
        vals = '{8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_checks++;
            if (bus.o_VALID !== 1'b1 || bus.o_OUTPUT !== vals[i]) begin
                n_fail++;
                $display("FAIL pop%0d: valid=%b out=%h required valid=1 out=%h",
                         i, bus.o_VALID, bus.o_OUTPUT, vals[i]);
            end
            $display("pop: valid=%b out=%h count=%0d", bus.o_VALID, bus.o_OUTPUT, bus.o_COUNT);
        end
        n_checks++;
        if (bus.o_STACK_EMPTY !== 1'b1 || bus.o_TOP !== 8'h00) begin
            n_fail++;
            $display("FAIL pop_empty: empty=%b top=%h required empty=1 top=00",
                     bus.o_STACK_EMPTY, bus.o_TOP);
        end
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++;
        if (bus.o_UNDERFLOW !== 1'b1 || bus.o_VALID !== 1'b0 || bus.o_OUTPUT !== 8'h11) begin
            n_fail++;
            $display("FAIL underflow: unf=%b valid=%b out=%h required unf=1 valid=0 out=11",
                     bus.o_UNDERFLOW, bus.o_VALID, bus.o_OUTPUT);
        end
        $display("pop on empty: unf=%b valid=%b", bus.o_UNDERFLOW, bus.o_VALID);
    endtask

    task automatic test_replace();
        do_cycle(1'b1, 1'b0, 1'b0, 8'hA0);
        n_checks++;
        if (bus.o_UNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_pulse: unf=%b required 0", bus.o_UNDERFLOW);
        end
        do_cycle(1'b1, 1'b0, 1'b0, 8'hB0);
        do_cycle(1'b1, 1'b1, 1'b0, 8'hC0);
        n_checks++;
        if (bus.o_OUTPUT !== 8'hB0 || bus.o_VALID !== 1'b1 || bus.o_COUNT !== 3'd2 || bus.o_TOP !== 8'hC0
            || bus.o_OVERFLOW !== 1'b0 || bus.o_UNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL replace_top: out=%h valid=%b count=%0d top=%h ovf=%b unf=%b required B0 1 2 C0 0 0",
                     bus.o_OUTPUT, bus.o_VALID, bus.o_COUNT, bus.o_TOP, bus.o_OVERFLOW, bus.o_UNDERFLOW);
        end
        $display("push C0+pop: out=%h valid=%b count=%0d top=%h", bus.o_OUTPUT, bus.o_VALID, bus.o_COUNT, bus.o_TOP);
    endtask

    task automatic test_passthrough();
        do_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        do_cycle(1'b1, 1'b1, 1'b0, 8'h7E);
        n_checks++;
        if (bus.o_OUTPUT !== 8'h7E || bus.o_VALID !== 1'b1 || bus.o_COUNT !== 3'd0
            || bus.o_OVERFLOW !== 1'b0 || bus.o_UNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL passthrough: out=%h valid=%b count=%0d ovf=%b unf=%b required 7E 1 0 0 0",
                     bus.o_OUTPUT, bus.o_VALID, bus.o_COUNT, bus.o_OVERFLOW, bus.o_UNDERFLOW);
        end
        $display("empty push 7E+pop: out=%h valid=%b count=%0d", bus.o_OUTPUT, bus.o_VALID, bus.o_COUNT);
    endtask

    task automatic test_reset_midstream();
        do_cycle(1'b1, 1'b0, 1'b0, 8'h01);
        do_cycle(1'b1, 1'b0, 1'b0, 8'h02);
        do_cycle(1'b1, 1'b0, 1'b0, 8'h03);
        do_cycle(1'b0, 1'b1, 1'b1, 8'h00);
        n_checks++;
        if (bus.o_COUNT !== 3'd0 || bus.o_VALID !== 1'b0 || bus.o_STACK_EMPTY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: count=%0d valid=%b empty=%b required 0 0 1",
                     bus.o_COUNT, bus.o_VALID, bus.o_STACK_EMPTY);
        end
        do_cycle(1'b1, 1'b0, 1'b0, 8'h99);
        n_checks++;
        if (bus.o_TOP !== 8'h99 || bus.o_COUNT !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_mid_push: top=%h count=%0d required top=99 count=1",
                     bus.o_TOP, bus.o_COUNT);
        end
        $display("reset with pop, then push 99: top=%h count=%0d", bus.o_TOP, bus.o_COUNT);
    endtask

    task automatic test_random();
        logic [DW+DW+3+6-1:0] obs;
        logic [DW+DW+3+6-1:0] exp;
        logic wr, rd, rs;
        for (int n = 0; n < 400; n++) begin
            wr = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 45);
            rs = ($urandom_range(0, 59) == 0);
            do_cycle(wr, rd, rs, 8'($urandom_range(0, 255)));
            obs = {bus.o_OUTPUT, bus.o_TOP, bus.o_COUNT, bus.o_VALID, bus.o_OVERFLOW,
                   bus.o_UNDERFLOW, bus.o_STACK_FULL, bus.o_STACK_EMPTY, bus.o_ALMOST_FULL};
            exp = {exp_out, exp_top(), 3'(q.size()), exp_valid, exp_ovf, exp_unf,
                   q.size() == DEPTH, q.size() == 0, exp_af()};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random%0d: out/top/cnt/v/ovf/unf/f/e/af got %h required %h", n, obs, exp);
            end else begin
                $display("rand %0d wr=%b rd=%b rst=%b: out=%h top=%h count=%0d valid=%b",
                         n, wr, rd, rs, bus.o_OUTPUT, bus.o_TOP, bus.o_COUNT, bus.o_VALID);
            end
        end
    endtask

    initial begin
        bus.i_WRITE_REQUEST = 1'b0;
        bus.i_READ_REQUEST  = 1'b0;
        bus.i_INPUT         = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_pop_all();
        test_replace();
        test_passthrough();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised LIFO buffer; generalises the fixed 2-entry stack to arbitrary depth and width.
- Adds: correctly sized pointer and occupancy count, defined simultaneous push/pop, registered pop data with valid strobe, a combinational top-of-stack peek, and overflow/underflow error pulses.
- Used as a return-address/operand stack next to small controllers.

Parameters:
- p_STACK_DEPTH, 8, number of entries; must be >= 2.
- p_DATA_WIDTH, 8, entry width in bits.
- p_AF_THRESHOLD, 6, o_ALMOST_FULL asserts when count >= this value; range 1..p_STACK_DEPTH.

Ports:
- i_CLK  input  1  clock; all logic on the rising edge.
- i_RESET  input  1  synchronous, active-high reset.
- i_WRITE_REQUEST  input  1  push i_INPUT.
- i_READ_REQUEST  input  1  pop top entry.
- i_INPUT  input  p_DATA_WIDTH  push data.
- o_OUTPUT  output  p_DATA_WIDTH  registered pop data.
- o_VALID  output  1  one-cycle strobe; o_OUTPUT holds data from the pop accepted on the previous edge.
- o_TOP  output  p_DATA_WIDTH  combinational peek of mem[count-1]; 0 when empty.
- o_COUNT  output  $clog2(p_STACK_DEPTH+1)  current occupancy.
- o_STACK_FULL  output  1  count == p_STACK_DEPTH.
- o_STACK_EMPTY  output  1  count == 0.
- o_ALMOST_FULL  output  1  see Optional Feature.
- o_OVERFLOW  output  1  one-cycle pulse: push dropped.
- o_UNDERFLOW  output  1  one-cycle pulse: pop dropped.

Behaviour:
- Reset (synchronous, active-high, sampled on the i_CLK rising edge):
  - count=0, o_OUTPUT=0, o_VALID=0, o_OVERFLOW=0, o_UNDERFLOW=0.
  - Memory contents are not cleared.
  - Reset wins over any request in the same cycle.
  - Reset mid-stream discards all entries; o_VALID is 0 on the cycle after reset.
- Count register:
  - The count register is the pointer. The next free slot is mem[count]; the top is mem[count-1].
  - Width is $clog2(p_STACK_DEPTH+1), so the pointer never wraps.
- Flags: o_STACK_FULL, o_STACK_EMPTY, o_COUNT and o_TOP are decoded combinationally from registered state only, with no input-to-output paths.
- Push only:
  - Not full: mem[count] <= i_INPUT; count+1.
  - Full: data dropped, count unchanged, o_OVERFLOW=1 for one cycle.
- Pop only:
  - Not empty: o_OUTPUT <= mem[count-1]; o_VALID=1 next cycle; count-1.
  - Empty: o_UNDERFLOW=1 for one cycle, o_VALID=0, o_OUTPUT holds its last value.
- Push and pop in the same cycle:
  - Not empty (including full): replace-top. o_OUTPUT <= old mem[count-1]; mem[count-1] <= i_INPUT; count unchanged; o_VALID=1; no error.
  - Empty: pass-through. o_OUTPUT <= i_INPUT; o_VALID=1; count stays 0; no error.
- Latency:
  - Pop data appears one cycle after the request edge.
  - A pushed value is visible on o_TOP the cycle after the push.
- o_VALID, o_OVERFLOW and o_UNDERFLOW are single-cycle. Back-to-back pops give back-to-back strobes.
- No state machine beyond count; every request is accepted or rejected in a single cycle.

Optional Feature:
- Macro LIFO_STACK_ALMOST_FULL_EN.
- Defined: o_ALMOST_FULL = (count >= p_AF_THRESHOLD), decoded from the registered count; 0 during and after reset.
- Undefined: o_ALMOST_FULL is tied to 0 and no comparator is built. The port is present in both builds.

Test Plan (p_STACK_DEPTH=4, p_DATA_WIDTH=8, p_AF_THRESHOLD=3):
- Reset, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles:
  - o_COUNT goes 1,2,3,4; o_TOP=0x44; o_STACK_FULL=1.
  - o_ALMOST_FULL=1 from count 3 with the macro defined, otherwise always 0.
- From full, push 0x55 -> o_OVERFLOW pulses one cycle; o_COUNT=4; o_TOP=0x44.
- Four consecutive pops:
  - o_VALID high on four consecutive cycles; o_OUTPUT = 0x44, 0x33, 0x22, 0x11.
  - o_STACK_EMPTY=1 afterwards. A fifth pop -> o_UNDERFLOW pulses; o_VALID=0.
- Push 0xA0, 0xB0, then push 0xC0 and pop in the same cycle:
  - o_OUTPUT=0xB0 with o_VALID=1; o_COUNT=2; o_TOP=0xC0.
- Empty stack, push 0x7E and pop in the same cycle -> next cycle o_OUTPUT=0x7E, o_VALID=1, o_COUNT=0, no error pulse.
- Push 3 entries, then assert i_RESET together with a pop:
  - Next cycle o_COUNT=0, o_VALID=0, o_STACK_EMPTY=1.
  - A subsequent push of 0x99 gives o_TOP=0x99.
